mc_ctrl: RTL and testbench

- Multi-cycle MIPS control unit: a Moore FSM that sequences a shared-ALU, single-memory-port datapath through fetch/decode/execute/memory/writeback.
- Drives every enable and mux select of the datapath, one step per clock.
- Sits inside `mips` between the externally held IR (opcode/funct fields) and the datapath.
- Counts retired instructions for bench-side CPI checks.

---
 rtl/mc_ctrl_if.sv | 36 +++
 rtl/mc_ctrl.sv | 175 +++++++++++++++++
 tb/tb_mc_ctrl.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_if.sv
// rtl/mc_ctrl_if.sv - control bundle between the multi-cycle controller and the MIPS datapath
interface mc_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             zero;
    logic             pc_wr;
    logic             ir_wr;
    logic             reg_wr;
    logic             mem_wr;
    logic [1:0]       reg_dst;
    logic [1:0]       wd_sel;
    logic             alu_src;
    logic [2:0]       alu_op;
    logic [1:0]       ext_op;
    logic [1:0]       pc_src;
    logic [3:0]       state;
    logic             illegal;
    logic             instr_done;
    logic [CNT_W-1:0] retired;

    // Controller side: reads IR fields and the ALU flag, drives every datapath control
    modport master (
        input  opcode, funct, zero,
        output pc_wr, ir_wr, reg_wr, mem_wr, reg_dst, wd_sel, alu_src,
               alu_op, ext_op, pc_src, state, illegal, instr_done, retired
    );

    // Datapath side: supplies IR fields and the ALU flag, consumes the controls
    modport slave (
        output opcode, funct, zero,
        input  pc_wr, ir_wr, reg_wr, mem_wr, reg_dst, wd_sel, alu_src,
               alu_op, ext_op, pc_src, state, illegal, instr_done, retired
    );
endinterface

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - Moore FSM control unit for the multi-cycle MIPS datapath
module mc_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic     clk,
    input  logic     reset,
    mc_ctrl_if.master ctl
);
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXE    = 4'd2,
        S_MADDR  = 4'd3,
        S_MRD    = 4'd4,
        S_MWR    = 4'd5,
        S_WB     = 4'd6,
        S_BR     = 4'd7,
        S_JMP    = 4'd8
    } state_t;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_OR   = 3'd2;
    localparam logic [2:0] ALU_LUI  = 3'd3;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic is_r, is_addu, is_subu, is_jr, is_ori, is_lui;
    logic is_lw, is_sw, is_beq, is_j, is_jal;
    logic is_alu, is_mem, is_jump, legal;

    logic             pc_wr, ir_wr, reg_wr, mem_wr, alu_src;
    logic [1:0]       reg_dst, wd_sel, ext_op, pc_src;
    logic [2:0]       alu_op;
    logic             illegal, instr_done;

    // IR is held by the datapath, so decoding straight off opcode/funct is stable after FETCH
    always_comb begin
        is_r    = (ctl.opcode == 6'h00);
        is_addu = is_r && (ctl.funct == 6'h21);
        is_subu = is_r && (ctl.funct == 6'h23);
        is_jr   = is_r && (ctl.funct == 6'h08);
        is_ori  = (ctl.opcode == 6'h0D);
        is_lui  = (ctl.opcode == 6'h0F);
        is_lw   = (ctl.opcode == 6'h23);
        is_sw   = (ctl.opcode == 6'h2B);
        is_beq  = (ctl.opcode == 6'h04);
        is_j    = (ctl.opcode == 6'h02);
        is_jal  = (ctl.opcode == 6'h03);
        is_alu  = is_addu | is_subu | is_ori | is_lui;
        is_mem  = is_lw | is_sw;
        is_jump = is_j | is_jal | is_jr;
        legal   = is_alu | is_mem | is_beq | is_jump;
    end

    // Next-state sequencing; unsupported opcodes fall straight back to FETCH as a nop
    always_comb begin
        state_d = S_FETCH;
        unique case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                if (is_alu)       state_d = S_EXE;
                else if (is_mem)  state_d = S_MADDR;
                else if (is_beq)  state_d = S_BR;
                else if (is_jump) state_d = S_JMP;
                else              state_d = S_FETCH;
            end
            S_EXE:    state_d = S_WB;
            S_MADDR:  state_d = is_lw ? S_MRD : S_MWR;
            S_MRD:    state_d = S_WB;
            default:  state_d = S_FETCH;
        endcase
    end

    // Moore outputs per state; everything is held at zero while reset is high
    always_comb begin
        pc_wr      = 1'b0;
        ir_wr      = 1'b0;
        reg_wr     = 1'b0;
        mem_wr     = 1'b0;
        reg_dst    = 2'd0;
        wd_sel     = 2'd0;
        alu_src    = 1'b0;
        alu_op     = ALU_ADD;
        ext_op     = 2'd0;
        pc_src     = 2'd0;
        illegal    = 1'b0;
        instr_done = 1'b0;
        if (!reset) begin
            unique case (state_q)
                S_FETCH: begin
                    ir_wr = 1'b1;
                    pc_wr = 1'b1;
                end
                S_DECODE: begin
                    if (!legal) begin
                        illegal    = 1'b1;
                        instr_done = 1'b1;
                    end
                end
                S_EXE: begin
                    if (is_subu) alu_op = ALU_SUB;
                    if (is_ori)  alu_op = ALU_OR;
                    if (is_lui)  alu_op = ALU_LUI;
                    alu_src = is_ori | is_lui;
                end
                S_MADDR: begin
                    alu_src = 1'b1;
                    ext_op  = 2'd1;
                end
                S_MWR: begin
                    mem_wr     = 1'b1;
                    instr_done = 1'b1;
                end
                S_WB: begin
                    reg_wr     = 1'b1;
                    instr_done = 1'b1;
                    reg_dst    = is_r  ? 2'd1 : 2'd0;
                    wd_sel     = is_lw ? 2'd1 : 2'd0;
                end
                S_BR: begin
                    alu_op     = ALU_SUB;
                    ext_op     = 2'd2;
                    pc_src     = 2'd1;
                    pc_wr      = ctl.zero;
                    instr_done = 1'b1;
                end
                S_JMP: begin
                    pc_wr      = 1'b1;
                    instr_done = 1'b1;
                    pc_src     = is_jr ? 2'd3 : 2'd2;
                    if (is_jal) begin
                        reg_wr  = 1'b1;
                        reg_dst = 2'd2;
                        wd_sel  = 2'd2;
                    end
                end
                default: ;
            endcase
        end
    end

    // Retired counter wraps silently; instr_done is already gated off during reset
    always_comb begin
        retired_d = retired_q;
        if (instr_done) retired_d = retired_q + CNT_W'(1);
    end

    // State and counter registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    assign ctl.pc_wr      = pc_wr;
    assign ctl.ir_wr      = ir_wr;
    assign ctl.reg_wr     = reg_wr;
    assign ctl.mem_wr     = mem_wr;
    assign ctl.reg_dst    = reg_dst;
    assign ctl.wd_sel     = wd_sel;
    assign ctl.alu_src    = alu_src;
    assign ctl.alu_op     = alu_op;
    assign ctl.ext_op     = ext_op;
    assign ctl.pc_src     = pc_src;
    assign ctl.illegal    = illegal;
    assign ctl.instr_done = instr_done;
    assign ctl.state      = reset ? 4'd0 : state_q;
    assign ctl.retired    = reset ? '0 : retired_q;
endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - directed self-checking bench for mc_ctrl
module tb_mc_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mc_ctrl_if #(.CNT_W(32)) bus ();

    mc_ctrl #(.CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .ctl   (bus.master)
    );

    logic [62:0] all_outs;
    assign all_outs = {bus.pc_wr, bus.ir_wr, bus.reg_wr, bus.mem_wr, bus.reg_dst, bus.wd_sel,
                       bus.alu_src, bus.alu_op, bus.ext_op, bus.pc_src, bus.state,
                       bus.illegal, bus.instr_done, bus.retired};

    task automatic test_reset();
        reset = 1'b1;
        bus.opcode = 6'($urandom);
        bus.funct  = 6'($urandom);
        bus.zero   = 1'b1;
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (all_outs !== '0) begin
                errors++;
                $display("FAIL reset_outs got %h want 0", all_outs);
            end
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({bus.state, bus.ir_wr, bus.pc_wr, bus.pc_src} !== {4'd0, 1'b1, 1'b1, 2'd0}) begin
            errors++;
            $display("FAIL reset_first_fetch got st=%0d ir=%b pc=%b src=%0d want st=0 ir=1 pc=1 src=0",
                     bus.state, bus.ir_wr, bus.pc_wr, bus.pc_src);
        end
    endtask

    task automatic test_addu();
        logic [3:0]  exp [4];
        logic [31:0] r0;
        exp = '{4'd0, 4'd1, 4'd2, 4'd6};
        bus.opcode = 6'h00; bus.funct = 6'h21;
        r0 = bus.retired;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.state !== exp[i]) begin
                errors++;
                $display("FAIL addu_state[%0d] got %0d want %0d", i, bus.state, exp[i]);
            end
            if (i == 2) begin
                checks++;
                if ({bus.alu_op, bus.alu_src} !== {3'd0, 1'b0}) begin
                    errors++;
                    $display("FAIL addu_exe got op=%0d src=%b want op=0 src=0", bus.alu_op, bus.alu_src);
                end
            end
            if (i == 3) begin
                checks++;
                if ({bus.reg_wr, bus.reg_dst, bus.wd_sel, bus.instr_done} !== {1'b1, 2'd1, 2'd0, 1'b1}) begin
                    errors++;
                    $display("FAIL addu_wb got rw=%b dst=%0d wd=%0d done=%b want 1 1 0 1",
                             bus.reg_wr, bus.reg_dst, bus.wd_sel, bus.instr_done);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (bus.state !== 4'd0 || bus.retired !== r0 + 32'd1) begin
            errors++;
            $display("FAIL addu_end got st=%0d ret=%0d want st=0 ret=%0d", bus.state, bus.retired, r0 + 1);
        end
    endtask

    task automatic test_lw_sw();
        logic [3:0]  exp_lw [5];
        logic [3:0]  exp_sw [4];
        logic [31:0] r0;
        int          mw;
        exp_lw = '{4'd0, 4'd1, 4'd3, 4'd4, 4'd6};
        exp_sw = '{4'd0, 4'd1, 4'd3, 4'd5};
        r0 = bus.retired;
        bus.opcode = 6'h23; bus.funct = 6'h15;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.state !== exp_lw[i]) begin
                errors++;
                $display("FAIL lw_state[%0d] got %0d want %0d", i, bus.state, exp_lw[i]);
            end
            if (i == 2) begin
                checks++;
                if ({bus.alu_op, bus.alu_src, bus.ext_op} !== {3'd0, 1'b1, 2'd1}) begin
                    errors++;
                    $display("FAIL lw_maddr got op=%0d src=%b ext=%0d want 0 1 1", bus.alu_op, bus.alu_src, bus.ext_op);
                end
            end
            if (i == 4) begin
                checks++;
                if ({bus.reg_wr, bus.reg_dst, bus.wd_sel} !== {1'b1, 2'd0, 2'd1}) begin
                    errors++;
                    $display("FAIL lw_wb got rw=%b dst=%0d wd=%0d want 1 0 1", bus.reg_wr, bus.reg_dst, bus.wd_sel);
                end
            end
            @(negedge clk);
        end
        bus.opcode = 6'h2B;
        mw = 0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.state !== exp_sw[i]) begin
                errors++;
                $display("FAIL sw_state[%0d] got %0d want %0d", i, bus.state, exp_sw[i]);
            end
            if (bus.mem_wr === 1'b1) mw++;
            @(negedge clk);
        end
        checks++;
        if (mw != 1) begin
            errors++;
            $display("FAIL sw_mem_wr_cycles got %0d want 1", mw);
        end
        checks++;
        if (bus.state !== 4'd0 || bus.retired !== r0 + 32'd2) begin
            errors++;
            $display("FAIL lw_sw_end got st=%0d ret=%0d want st=0 ret=%0d", bus.state, bus.retired, r0 + 2);
        end
    endtask

    task automatic test_beq();
        for (int k = 0; k < 2; k++) begin
            bus.opcode = 6'h04; bus.funct = 6'h00;
            bus.zero   = (k == 0);
            @(negedge clk);
            @(negedge clk);
            checks++;
            if ({bus.state, bus.pc_wr, bus.pc_src, bus.alu_op, bus.ext_op, bus.instr_done} !==
                {4'd7, (k == 0) ? 1'b1 : 1'b0, 2'd1, 3'd1, 2'd2, 1'b1}) begin
                errors++;
                $display("FAIL beq_br[z=%0d] got st=%0d pcwr=%b src=%0d op=%0d ext=%0d done=%b", 1 - k,
                         bus.state, bus.pc_wr, bus.pc_src, bus.alu_op, bus.ext_op, bus.instr_done);
            end
            @(negedge clk);
            checks++;
            if (bus.state !== 4'd0) begin
                errors++;
                $display("FAIL beq_latency[z=%0d] got st=%0d want 0", 1 - k, bus.state);
            end
        end
        bus.zero = 1'b1;
    endtask

    task automatic test_jumps_illegal();
        logic [31:0] r0;
        r0 = bus.retired;
        bus.opcode = 6'h03; bus.funct = 6'h00;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({bus.state, bus.pc_wr, bus.reg_wr, bus.reg_dst, bus.wd_sel, bus.pc_src} !==
            {4'd8, 1'b1, 1'b1, 2'd2, 2'd2, 2'd2}) begin
            errors++;
            $display("FAIL jal_jmp got st=%0d pcwr=%b rw=%b dst=%0d wd=%0d src=%0d", bus.state,
                     bus.pc_wr, bus.reg_wr, bus.reg_dst, bus.wd_sel, bus.pc_src);
        end
        @(negedge clk);
        bus.opcode = 6'h00; bus.funct = 6'h08;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({bus.state, bus.pc_wr, bus.reg_wr, bus.pc_src} !== {4'd8, 1'b1, 1'b0, 2'd3}) begin
            errors++;
            $display("FAIL jr_jmp got st=%0d pcwr=%b rw=%b src=%0d want 8 1 0 3", bus.state,
                     bus.pc_wr, bus.reg_wr, bus.pc_src);
        end
        @(negedge clk);
        bus.opcode = 6'h3F;
        @(negedge clk);
        checks++;
        if ({bus.state, bus.illegal, bus.instr_done} !== {4'd1, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL illegal_decode got st=%0d ill=%b done=%b want 1 1 1", bus.state, bus.illegal, bus.instr_done);
        end
        @(negedge clk);
        checks++;
        if ({bus.state, bus.illegal} !== {4'd0, 1'b0} || bus.retired !== r0 + 32'd3) begin
            errors++;
            $display("FAIL illegal_end got st=%0d ill=%b ret=%0d want st=0 ill=0 ret=%0d", bus.state,
                     bus.illegal, bus.retired, r0 + 3);
        end
    endtask

    task automatic test_wrap_and_abort();
        bus.opcode = 6'h0D; bus.funct = 6'h00;
        force dut.retired_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.retired_q;
        checks++;
        if (bus.retired !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL wrap_preload got %h want ffffffff", bus.retired);
        end
        @(negedge clk);
        checks++;
        if ({bus.state, bus.alu_op, bus.alu_src, bus.ext_op} !== {4'd2, 3'd2, 1'b1, 2'd0}) begin
            errors++;
            $display("FAIL ori_exe got st=%0d op=%0d src=%b ext=%0d want 2 2 1 0", bus.state,
                     bus.alu_op, bus.alu_src, bus.ext_op);
        end
        @(negedge clk);
        checks++;
        if ({bus.state, bus.reg_wr, bus.reg_dst, bus.wd_sel} !== {4'd6, 1'b1, 2'd0, 2'd0}) begin
            errors++;
            $display("FAIL ori_wb got st=%0d rw=%b dst=%0d wd=%0d want 6 1 0 0", bus.state,
                     bus.reg_wr, bus.reg_dst, bus.wd_sel);
        end
        @(negedge clk);
        checks++;
        if (bus.retired !== 32'd0 || bus.state !== 4'd0) begin
            errors++;
            $display("FAIL wrap_result got ret=%h st=%0d want 0 0", bus.retired, bus.state);
        end
        bus.opcode = 6'h23;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.state !== 4'd3) begin
            errors++;
            $display("FAIL abort_reach_maddr got st=%0d want 3", bus.state);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (all_outs !== '0) begin
            errors++;
            $display("FAIL abort_outs_zero got %h want 0", all_outs);
        end
        @(negedge clk);
        bus.opcode = 6'h3F;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.state === 4'd4 || bus.state === 4'd6 || bus.retired !== 32'd0 + ((i == 2) ? 32'd1 : 32'd0)) begin
                errors++;
                $display("FAIL abort_cycle[%0d] got st=%0d ret=%0d", i, bus.state, bus.retired);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_addu();
        test_lw_sw();
        test_beq();
        test_jumps_illegal();
        test_wrap_and_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
